// File: rtl/rom_dl_packer.sv
// Packs the byte-wide ROM download stream into 16-bit SDRAM writes with byte enables.
// A small word FIFO absorbs write latency; rom_loaded flags the point where every byte is in SDRAM.
module rom_dl_packer #(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        res_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [23:0] sd_addr,
  output logic [15:0] sd_din,
  output logic [1:0]  sd_wtbt,
  output logic        sd_we,
  input  logic        sd_ready,
  output logic        rom_loaded,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  typedef struct packed {
    logic [23:0] waddr;
    logic [15:0] data;
    logic [1:0]  mask;
  } word_t;

  logic             dl_q, dl_d;
  logic             end_q, end_d;
  logic             ended_q, ended_d;
  logic             pend_vld_q, pend_vld_d;
  logic [23:0]      pend_waddr_q, pend_waddr_d;
  logic [15:0]      pend_data_q, pend_data_d;
  logic [1:0]       pend_mask_q, pend_mask_d;
  word_t            mem_q [FIFO_DEPTH];
  word_t            mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [23:0]      sd_addr_q, sd_addr_d;
  logic [15:0]      sd_din_q, sd_din_d;
  logic [1:0]       sd_wtbt_q, sd_wtbt_d;
  logic             sd_we_q, sd_we_d;
  logic             overflow_q, overflow_d;
  logic             rom_loaded_q, rom_loaded_d;
  logic             busy_q, busy_d;

  logic             acc;
  logic             dl_rise;
  logic [23:0]      byte_waddr;
  logic             byte_lane;
  logic [15:0]      lane_data;
  logic [1:0]       lane_mask;
  logic [15:0]      merged_data;
  logic [1:0]       merged_mask;
  logic             push;
  word_t            push_word;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic [PTR_W-1:0] rd_next;
  word_t            head;

  assign acc         = ioctl_download & ioctl_wr & (ioctl_index == ROM_INDEX);
  assign dl_rise     = ioctl_download & ~dl_q;
  assign byte_waddr  = ioctl_addr[24:1];
  assign byte_lane   = ioctl_addr[0];
  assign lane_data   = byte_lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
  assign lane_mask   = byte_lane ? 2'b10 : 2'b01;
  assign merged_data = byte_lane ? {ioctl_dout, pend_data_q[7:0]} : {pend_data_q[15:8], ioctl_dout};
  assign merged_mask = pend_mask_q | lane_mask;
  assign rd_next     = rd_ptr_q + PTR_W'(1);

  always_comb begin
    dl_d         = ioctl_download;
    end_d        = dl_q & ~ioctl_download;
    ended_d      = ended_q;
    pend_vld_d   = pend_vld_q;
    pend_waddr_d = pend_waddr_q;
    pend_data_d  = pend_data_q;
    pend_mask_d  = pend_mask_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    state_d      = state_q;
    sd_addr_d    = sd_addr_q;
    sd_din_d     = sd_din_q;
    sd_wtbt_d    = sd_wtbt_q;
    sd_we_d      = sd_we_q;
    overflow_d   = overflow_q;
    rom_loaded_d = rom_loaded_q;
    push         = 1'b0;
    push_word    = '0;
    head         = '0;

    // Byte intake: load, merge, or evict a partial word to make room.
    if (acc) begin
      if (!pend_vld_q) begin
        pend_vld_d   = 1'b1;
        pend_waddr_d = byte_waddr;
        pend_data_d  = lane_data;
        pend_mask_d  = lane_mask;
      end else if (pend_waddr_q == byte_waddr) begin
        if (merged_mask == 2'b11) begin
          push       = 1'b1;
          push_word  = '{waddr: pend_waddr_q, data: merged_data, mask: merged_mask};
          pend_vld_d = 1'b0;
        end else begin
          pend_data_d = merged_data;
          pend_mask_d = merged_mask;
        end
      end else begin
        push         = 1'b1;
        push_word    = '{waddr: pend_waddr_q, data: pend_data_q, mask: pend_mask_q};
        pend_waddr_d = byte_waddr;
        pend_data_d  = lane_data;
        pend_mask_d  = lane_mask;
      end
    end else if (end_q && pend_vld_q) begin
      push       = 1'b1;
      push_word  = '{waddr: pend_waddr_q, data: pend_data_q, mask: pend_mask_q};
      pend_vld_d = 1'b0;
    end

    // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves this cycle.
    pop     = (state_q == S_REQ) & sd_we_q & sd_ready;
    full    = (count_q == CNT_W'(FIFO_DEPTH));
    push_ok = push & (~full | pop);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    case (state_q)
      S_IDLE: begin
        sd_we_d = 1'b0;
        if (count_q != '0) begin
          head      = mem_q[rd_ptr_q];
          sd_addr_d = head.waddr;
          sd_din_d  = head.data;
          sd_wtbt_d = head.mask;
          sd_we_d   = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (pop) begin
          sd_we_d = 1'b0;
          if (count_q > CNT_W'(1)) begin
            head      = mem_q[rd_next];
            sd_addr_d = head.waddr;
            sd_din_d  = head.data;
            sd_wtbt_d = head.mask;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          sd_we_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sd_we_d = 1'b0;
      end
    endcase

    if (dl_rise) begin
      overflow_d = 1'b0;
    end
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end

    busy_d = pend_vld_d | (count_d != '0) | (state_d != S_IDLE);

    // busy_q mirrors the current state, so rom_loaded waits for the flushed word to drain.
    if (end_q) begin
      ended_d = 1'b1;
    end
    if (ended_q && !busy_q) begin
      rom_loaded_d = 1'b1;
    end
    if (dl_rise) begin
      ended_d      = 1'b0;
      rom_loaded_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      dl_q         <= 1'b0;
      end_q        <= 1'b0;
      ended_q      <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_waddr_q <= '0;
      pend_data_q  <= '0;
      pend_mask_q  <= '0;
      mem_q        <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      sd_addr_q    <= '0;
      sd_din_q     <= '0;
      sd_wtbt_q    <= '0;
      sd_we_q      <= 1'b0;
      overflow_q   <= 1'b0;
      rom_loaded_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      dl_q         <= dl_d;
      end_q        <= end_d;
      ended_q      <= ended_d;
      pend_vld_q   <= pend_vld_d;
      pend_waddr_q <= pend_waddr_d;
      pend_data_q  <= pend_data_d;
      pend_mask_q  <= pend_mask_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      sd_addr_q    <= sd_addr_d;
      sd_din_q     <= sd_din_d;
      sd_wtbt_q    <= sd_wtbt_d;
      sd_we_q      <= sd_we_d;
      overflow_q   <= overflow_d;
      rom_loaded_q <= rom_loaded_d;
      busy_q       <= busy_d;
    end
  end

  assign sd_addr    = sd_addr_q;
  assign sd_din     = sd_din_q;
  assign sd_wtbt    = sd_wtbt_q;
  assign sd_we      = sd_we_q;
  assign overflow   = overflow_q;
  assign rom_loaded = rom_loaded_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rom_dl_packer.sv
// Scoreboard bench for rom_dl_packer: expected SDRAM writes are queued as bytes are driven
// and compared in order as each write is accepted.
module tb_rom_dl_packer;

  logic        clk_sys = 1'b0;
  logic        res_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [23:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_wtbt;
  logic        sd_we;
  logic        sd_ready;
  logic        rom_loaded;
  logic        busy;
  logic        overflow;

  typedef struct packed {
    logic [23:0] a;
    logic [15:0] d;
    logic [1:0]  m;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_xfer   = 0;
  bit   after_xfer = 1'b0;
  bit   watch = 1'b0;
  bit   busy_seen = 1'b0;
  bit   we_seen = 1'b0;
  exp_t mon_e;
  logic [15:0] mon_m;

  always #5 clk_sys = ~clk_sys;

  rom_dl_packer #(.ROM_INDEX(8'd0), .FIFO_DEPTH(4)) dut (
    .clk_sys(clk_sys), .res_n(res_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .sd_addr(sd_addr), .sd_din(sd_din), .sd_wtbt(sd_wtbt),
    .sd_we(sd_we), .sd_ready(sd_ready), .rom_loaded(rom_loaded), .busy(busy),
    .overflow(overflow)
  );

  // Write monitor: each accepted write is checked against the head of the scoreboard.
  always @(negedge clk_sys) begin
    if (after_xfer) begin
      after_xfer = 1'b0;
      n_checks++;
      if (sd_we !== 1'b0) $display("FAIL we_gap: sd_we=%b required 0", sd_we);
      else n_pass++;
    end
    if (watch) begin
      if (busy === 1'b1) busy_seen = 1'b1;
      if (sd_we === 1'b1) we_seen = 1'b1;
    end
    if (res_n === 1'b1 && sd_we === 1'b1 && sd_ready === 1'b1) begin
      n_xfer++;
      after_xfer = 1'b1;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: addr=%h din=%h wtbt=%b required no write", sd_addr, sd_din, sd_wtbt);
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = {{8{mon_e.m[1]}}, {8{mon_e.m[0]}}};
        if (sd_addr !== mon_e.a || sd_wtbt !== mon_e.m || (sd_din & mon_m) !== (mon_e.d & mon_m))
          $display("FAIL write: addr=%h din=%h wtbt=%b required addr=%h din=%h wtbt=%b",
                   sd_addr, sd_din, sd_wtbt, mon_e.a, mon_e.d, mon_e.m);
        else n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] idx, input int a, input logic [7:0] d);
    ioctl_index = idx;
    ioctl_addr  = 25'(a);
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    tick(1);
    ioctl_wr    = 1'b0;
    tick(3);
  endtask

  task automatic expect_wr(input int a, input logic [15:0] d, input logic [1:0] m);
    exp_q.push_back({24'(a), d, m});
  endtask

  task automatic wait_loaded();
    for (int i = 0; i < 400; i++) begin
      if (rom_loaded === 1'b1 && exp_q.size() == 0) break;
      tick(1);
    end
  endtask

  task automatic test_reset();
    res_n = 1'b0; sd_ready = 1'b0; ioctl_download = 1'b0;
    ioctl_index = 8'd0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    #2;
    n_checks++;
    if ({sd_we, busy, rom_loaded, overflow, sd_wtbt} !== 6'b0 || sd_addr !== 24'd0 || sd_din !== 16'd0)
      $display("FAIL reset_in: we=%b busy=%b loaded=%b ovf=%b wtbt=%b addr=%h din=%h required all 0",
               sd_we, busy, rom_loaded, overflow, sd_wtbt, sd_addr, sd_din);
    else n_pass++;
    tick(2);
    res_n = 1'b1;
    tick(3);
    n_checks++;
    if ({sd_we, busy, rom_loaded, overflow} !== 4'b0)
      $display("FAIL reset_out: we=%b busy=%b loaded=%b ovf=%b required all 0", sd_we, busy, rom_loaded, overflow);
    else n_pass++;
  endtask

  task automatic test_basic();
    sd_ready = 1'b1;
    ioctl_download = 1'b1;
    tick(2);
    expect_wr(0, 16'h2211, 2'b11);
    send(8'd0, 0, 8'h11);
    ioctl_addr = 25'd1; ioctl_dout = 8'h22; ioctl_wr = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    @(negedge clk_sys);
    n_checks++;
    if (sd_we !== 1'b0) $display("FAIL latency_early: sd_we=%b required 0", sd_we);
    else n_pass++;
    @(negedge clk_sys);
    n_checks++;
    if (sd_we !== 1'b1) $display("FAIL latency_we: sd_we=%b required 1", sd_we);
    else n_pass++;
    tick(2);
    expect_wr(1, 16'h4433, 2'b11);
    send(8'd0, 2, 8'h33);
    send(8'd0, 3, 8'h44);
    n_checks++;
    if (rom_loaded !== 1'b0) $display("FAIL basic_not_loaded: rom_loaded=%b required 0", rom_loaded);
    else n_pass++;
    ioctl_download = 1'b0;
    wait_loaded();
    n_checks++;
    if (rom_loaded !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL basic_loaded: rom_loaded=%b busy=%b left=%0d required 1 0 0", rom_loaded, busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_odd_length();
    ioctl_download = 1'b1;
    tick(2);
    n_checks++;
    if (rom_loaded !== 1'b0) $display("FAIL odd_clear: rom_loaded=%b required 0", rom_loaded);
    else n_pass++;
    expect_wr(0, 16'hBBAA, 2'b11);
    expect_wr(1, 16'h00CC, 2'b01);
    send(8'd0, 0, 8'hAA);
    send(8'd0, 1, 8'hBB);
    send(8'd0, 2, 8'hCC);
    tick(8);
    n_checks++;
    if (sd_we !== 1'b0 || busy !== 1'b1 || exp_q.size() != 1)
      $display("FAIL odd_held: sd_we=%b busy=%b left=%0d required 0 1 1", sd_we, busy, exp_q.size());
    else n_pass++;
    ioctl_download = 1'b0;
    wait_loaded();
    n_checks++;
    if (rom_loaded !== 1'b1 || exp_q.size() != 0)
      $display("FAIL odd_loaded: rom_loaded=%b left=%0d required 1 0", rom_loaded, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_nonseq();
    ioctl_download = 1'b1;
    tick(2);
    expect_wr(2, 16'h5500, 2'b10);
    expect_wr(4, 16'h0066, 2'b01);
    send(8'd0, 5, 8'h55);
    send(8'd0, 8, 8'h66);
    ioctl_download = 1'b0;
    wait_loaded();
    n_checks++;
    if (rom_loaded !== 1'b1 || exp_q.size() != 0)
      $display("FAIL nonseq_loaded: rom_loaded=%b left=%0d required 1 0", rom_loaded, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    sd_ready = 1'b0;
    ioctl_download = 1'b1;
    tick(2);
    for (int k = 0; k < 12; k++) begin
      b = 8'hA0 + 8'(k);
      if (k % 2 == 1 && k < 8) expect_wr(k / 2, {b, b - 8'd1}, 2'b11);
      send(8'd0, k, b);
    end
    ioctl_download = 1'b0;
    tick(4);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: overflow=%b required 1", overflow);
    else n_pass++;
    n_checks++;
    if (sd_we !== 1'b1 || sd_addr !== 24'd0 || sd_din !== 16'hA1A0 || rom_loaded !== 1'b0)
      $display("FAIL ovf_stall: we=%b addr=%h din=%h loaded=%b required 1 000000 a1a0 0",
               sd_we, sd_addr, sd_din, rom_loaded);
    else n_pass++;
    sd_ready = 1'b1;
    wait_loaded();
    n_checks++;
    if (rom_loaded !== 1'b1 || overflow !== 1'b1 || exp_q.size() != 0)
      $display("FAIL ovf_drain: loaded=%b overflow=%b left=%0d required 1 1 0", rom_loaded, overflow, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_other_index();
    int x0;
    x0 = n_xfer;
    ioctl_download = 1'b1;
    tick(2);
    n_checks++;
    if (overflow !== 1'b0 || rom_loaded !== 1'b0)
      $display("FAIL idx_start: overflow=%b loaded=%b required 0 0", overflow, rom_loaded);
    else n_pass++;
    busy_seen = 1'b0; we_seen = 1'b0; watch = 1'b1;
    send(8'd1, 0, 8'h01);
    send(8'd1, 1, 8'h02);
    send(8'd1, 2, 8'h03);
    ioctl_download = 1'b0;
    wait_loaded();
    watch = 1'b0;
    n_checks++;
    if (rom_loaded !== 1'b1 || busy_seen || we_seen || n_xfer != x0)
      $display("FAIL idx_ignored: loaded=%b busy_seen=%b we_seen=%b writes=%0d required 1 0 0 0",
               rom_loaded, busy_seen, we_seen, n_xfer - x0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    sd_ready = 1'b0;
    ioctl_download = 1'b1;
    tick(2);
    for (int k = 0; k < 5; k++) send(8'd0, k, 8'h10 * 8'(k + 1));
    n_checks++;
    if (sd_we !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid_pre: sd_we=%b busy=%b required 1 1", sd_we, busy);
    else n_pass++;
    #2 res_n = 1'b0;
    #1;
    n_checks++;
    if ({sd_we, busy, rom_loaded, overflow, sd_wtbt} !== 6'b0 || sd_din !== 16'd0 || sd_addr !== 24'd0)
      $display("FAIL mid_async: we=%b busy=%b loaded=%b ovf=%b wtbt=%b din=%h addr=%h required all 0",
               sd_we, busy, rom_loaded, overflow, sd_wtbt, sd_din, sd_addr);
    else n_pass++;
    ioctl_download = 1'b0;
    tick(2);
    res_n = 1'b1;
    tick(6);
    n_checks++;
    if (rom_loaded !== 1'b0 || busy !== 1'b0 || sd_we !== 1'b0)
      $display("FAIL mid_noflush: loaded=%b busy=%b we=%b required 0 0 0", rom_loaded, busy, sd_we);
    else n_pass++;
    sd_ready = 1'b1;
    ioctl_download = 1'b1;
    tick(2);
    expect_wr(0, 16'h8877, 2'b11);
    expect_wr(1, 16'h0099, 2'b01);
    send(8'd0, 0, 8'h77);
    send(8'd0, 1, 8'h88);
    send(8'd0, 2, 8'h99);
    ioctl_download = 1'b0;
    wait_loaded();
    n_checks++;
    if (rom_loaded !== 1'b1 || exp_q.size() != 0)
      $display("FAIL mid_reload: loaded=%b left=%0d required 1 0", rom_loaded, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    sd_ready = 1'b0;
    ioctl_download = 1'b1;
    tick(2);
    expect_wr(0, 16'h0201, 2'b11);
    send(8'd0, 0, 8'h01);
    send(8'd0, 1, 8'h02);
    ioctl_download = 1'b0;
    tick(4);
    n_checks++;
    if (rom_loaded !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_pending: loaded=%b busy=%b required 0 1", rom_loaded, busy);
    else n_pass++;
    ioctl_download = 1'b1;
    tick(2);
    expect_wr(1, 16'h0403, 2'b11);
    send(8'd0, 2, 8'h03);
    send(8'd0, 3, 8'h04);
    sd_ready = 1'b1;
    ioctl_download = 1'b0;
    wait_loaded();
    n_checks++;
    if (rom_loaded !== 1'b1 || exp_q.size() != 0)
      $display("FAIL b2b_loaded: loaded=%b left=%0d required 1 0", rom_loaded, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_odd_length();
    test_nonseq();
    test_overflow();
    test_other_index();
    test_reset_mid();
    test_back_to_back();
    tick(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
